// File: rtl/fir_pkg.sv
// Shared types and widths for the FIR job scheduler.
// State codes are fixed because they are exported on stateOut.
package fir_pkg;

  localparam int IN_SAMPLE_WIDTH  = 16;
  localparam int OUT_SAMPLE_WIDTH = 32;
  localparam int COUNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    LOAD      = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; two_i bumps by two so that two
// drop events landing in the same cycle are both counted.
import fir_pkg::*;

module sat_counter #(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             nResetIn,
  input  logic             en_i,
  input  logic             two_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] TWO = (WIDTH+1)'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // next count, clamped at all-ones on carry out
  always_comb begin
    sum   = {1'b0, cnt_q} + (two_i ? TWO : ONE);
    cnt_d = cnt_q;
    if (en_i)
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  // count register
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_job_scheduler.sv
// Schedules SPI packets onto the FIR datapath with a one-entry
// pending slot, a done timeout and coefficient-load lockout.
import fir_pkg::*;

module fir_job_scheduler #(
  parameter int SAMPLES_NUM    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                   clk,
  input  logic                                   nResetIn,
  input  logic                                   pktValidIn,
  input  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0] pktDataIn,
  input  logic                                   firLoadIn,
  output logic                                   firStartOut,
  output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataOut,
  input  logic                                   firDoneIn,
  input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firResultIn,
  output logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] txDataOut,
  output logic                                   busyOut,
  output logic [1:0]                             stateOut,
  output logic [COUNT_WIDTH-1:0]                 dropCountOut,
  output logic [COUNT_WIDTH-1:0]                 timeoutCountOut
);

  localparam int IW = IN_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int OW = OUT_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pend_v_q, pend_v_d;
  logic [IW-1:0] pend_q, pend_d;
  logic [IW-1:0] fdata_q, fdata_d;
  logic [OW-1:0] res_q, res_d;
  logic [OW-1:0] tx_q, tx_d;
  logic          start_q, start_d;
  logic          drop_en, drop_two, tmo_en;

  // next state, datapath loads and counter enables
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    fdata_d  = fdata_q;
    res_d    = res_q;
    tx_d     = tx_q;
    start_d  = 1'b0;
    drop_en  = 1'b0;
    drop_two = 1'b0;
    tmo_en   = 1'b0;
    if (pktValidIn)
      tx_d = res_q;
    unique case (state_q)
      IDLE: begin
        if (firLoadIn) begin
          state_d  = LOAD;
          pend_v_d = 1'b0;
          drop_en  = pend_v_q | pktValidIn;
          drop_two = pend_v_q & pktValidIn;
        end else if (pend_v_q) begin
          state_d  = START;
          fdata_d  = pend_q;
          pend_v_d = pktValidIn;
          if (pktValidIn)
            pend_d = pktDataIn;
        end else if (pktValidIn) begin
          state_d = START;
          fdata_d = pktDataIn;
        end
      end
      START, WAIT_DONE: begin
        if (pktValidIn) begin
          if (pend_v_q) begin
            drop_en = 1'b1;
          end else begin
            pend_v_d = 1'b1;
            pend_d   = pktDataIn;
          end
        end
        if (state_q == START) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (firDoneIn) begin
          res_d   = firResultIn;
          state_d = IDLE;
        end else if (cnt_q == TLAST) begin
          tmo_en  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      LOAD: begin
        drop_en = pktValidIn;
        if (!firLoadIn)
          state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      fdata_q  <= '0;
      res_q    <= '0;
      tx_q     <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      fdata_q  <= fdata_d;
      res_q    <= res_d;
      tx_q     <= tx_d;
      start_q  <= start_d;
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop (
    .clk      (clk),
    .nResetIn (nResetIn),
    .en_i     (drop_en),
    .two_i    (drop_two),
    .cnt_o    (dropCountOut)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_tmo (
    .clk      (clk),
    .nResetIn (nResetIn),
    .en_i     (tmo_en),
    .two_i    (1'b0),
    .cnt_o    (timeoutCountOut)
  );

  assign firStartOut = start_q;
  assign firDataOut  = fdata_q;
  assign txDataOut   = tx_q;
  assign busyOut     = (state_q != IDLE);
  assign stateOut    = state_q;

endmodule

// File: tb/tb_fir_job_scheduler.sv
// Bench for fir_job_scheduler: job table plus hand sequences,
// with queues holding expected FIR inputs and tx buffers.
module tb_fir_job_scheduler;
  import fir_pkg::*;

  localparam int SN = 8;
  localparam int TO = 16;
  localparam int IW = 16 * SN;
  localparam int OW = 32 * SN;

  logic          clk = 1'b0;
  logic          nResetIn = 1'b0;
  logic          pktValidIn = 1'b0;
  logic [IW-1:0] pktDataIn = '0;
  logic          firLoadIn = 1'b0;
  logic          firStartOut;
  logic [IW-1:0] firDataOut;
  logic          firDoneIn = 1'b0;
  logic [OW-1:0] firResultIn = '0;
  logic [OW-1:0] txDataOut;
  logic          busyOut;
  logic [1:0]    stateOut;
  logic [15:0]   dropCountOut;
  logic [15:0]   timeoutCountOut;

  fir_job_scheduler #(
    .SAMPLES_NUM    (SN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .nResetIn        (nResetIn),
    .pktValidIn      (pktValidIn),
    .pktDataIn       (pktDataIn),
    .firLoadIn       (firLoadIn),
    .firStartOut     (firStartOut),
    .firDataOut      (firDataOut),
    .firDoneIn       (firDoneIn),
    .firResultIn     (firResultIn),
    .txDataOut       (txDataOut),
    .busyOut         (busyOut),
    .stateOut        (stateOut),
    .dropCountOut    (dropCountOut),
    .timeoutCountOut (timeoutCountOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    int          dly;
    logic [31:0] res;
    bit          tmo;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [255:0]  exp_job[$];
  logic [255:0]  exp_tx[$];
  bit            tx_pend = 0;
  logic [OW-1:0] res_m = '0;
  logic [15:0]   tmo_m = '0;
  vec_t          tv[6];

  function automatic logic [IW-1:0] mkpkt(input logic [15:0] b);
    logic [IW-1:0] p;
    for (int i = 0; i < SN; i++)
      p[16*i +: 16] = b + 16'(i);
    return p;
  endfunction

  function automatic logic [OW-1:0] mkres(input logic [31:0] r);
    return {SN{r}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (firStartOut) begin
      if (exp_job.size() == 0)
        chk("unexpected_start", 256'(1), 256'(0));
      else
        chk("fir_data", 256'(firDataOut), exp_job.pop_front());
    end
    if (tx_pend) begin
      tx_pend = 0;
      chk("tx_data", 256'(txDataOut), exp_tx.pop_front());
    end
  endtask

  task automatic send(input logic [15:0] b, input bit job);
    pktValidIn = 1'b1;
    pktDataIn  = mkpkt(b);
    exp_tx.push_back(256'(res_m));
    tx_pend = 1;
    if (job)
      exp_job.push_back(256'(mkpkt(b)));
    tick();
    pktValidIn = 1'b0;
  endtask

  task automatic done(input logic [31:0] r);
    firDoneIn   = 1'b1;
    firResultIn = mkres(r);
    tick();
    firDoneIn = 1'b0;
    res_m     = mkres(r);
  endtask

  task automatic wait_start(output int lat);
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      lat++;
      if (firStartOut)
        break;
    end
    if (!firStartOut)
      chk("start_seen", 256'(0), 256'(1));
  endtask

  initial begin
    int lat;
    int bn;
    int n;
    tv[0] = '{16'h0001, 10, 32'hA5A5A5A5, 1'b0};
    tv[1] = '{16'h1000, 3,  32'h12345678, 1'b0};
    tv[2] = '{16'h2000, 0,  32'hC0FFEE00, 1'b0};
    tv[3] = '{16'h3000, 0,  32'h0,        1'b1};
    tv[4] = '{16'hFFF0, 15, 32'h89ABCDEF, 1'b0};
    tv[5] = '{16'h0100, 5,  32'hDEADBEEF, 1'b0};

    tick();
    chk("rst_state", 256'(stateOut), 256'(0));
    chk("rst_busy", 256'(busyOut), 256'(0));
    chk("rst_start", 256'(firStartOut), 256'(0));
    chk("rst_fdata", 256'(firDataOut), 256'(0));
    chk("rst_tx", 256'(txDataOut), 256'(0));
    chk("rst_drop", 256'(dropCountOut), 256'(0));
    chk("rst_tmo", 256'(timeoutCountOut), 256'(0));
    nResetIn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      send(tv[v].base, 1);
      bn = busyOut ? 1 : 0;
      wait_start(lat);
      chk("start_latency", 256'(lat), 256'(2));
      bn += busyOut ? 1 : 0;
      if (tv[v].tmo) begin
        n = 0;
        while (stateOut != 2'd0 && n < 40) begin
          tick();
          n++;
        end
        tmo_m++;
        chk("timeout_cycles", 256'(n), 256'(TO));
        chk("timeout_count", 256'(timeoutCountOut), 256'(tmo_m));
      end else begin
        for (int d = 0; d < tv[v].dly; d++) begin
          tick();
          bn += busyOut ? 1 : 0;
        end
        done(tv[v].res);
        chk("busy_cycles", 256'(bn), 256'(tv[v].dly + 2));
        chk("idle_after_done", 256'(stateOut), 256'(0));
      end
    end

    send(16'h4000, 1);
    wait_start(lat);
    send(16'h4100, 1);
    send(16'h4200, 0);
    send(16'h4300, 0);
    chk("drop_two", 256'(dropCountOut), 256'(2));
    done(32'h0BADF00D);
    wait_start(lat);
    done(32'h22222222);
    chk("drop_hold", 256'(dropCountOut), 256'(2));

    send(16'h5000, 1);
    wait_start(lat);
    tick();
    firDoneIn   = 1'b1;
    firResultIn = mkres(32'h33333333);
    send(16'h5100, 1);
    firDoneIn = 1'b0;
    res_m     = mkres(32'h33333333);
    wait_start(lat);
    send(16'h5200, 1);
    done(32'h44444444);
    wait_start(lat);
    done(32'h55555555);

    send(16'h6000, 1);
    wait_start(lat);
    send(16'h6100, 0);
    firLoadIn = 1'b1;
    tick();
    chk("load_no_abort", 256'(stateOut), 256'(2));
    done(32'h66666666);
    chk("idle_before_load", 256'(stateOut), 256'(0));
    tick();
    chk("load_entry", 256'(stateOut), 256'(3));
    chk("load_pend_drop", 256'(dropCountOut), 256'(3));
    for (int c = 0; c < 48; c++) begin
      if (c == 5 || c == 20 || c == 35) begin
        send(16'h6200 + 16'(c), 0);
      end else if (c == 10) begin
        firDoneIn   = 1'b1;
        firResultIn = mkres(32'hBAD0BAD0);
        tick();
        firDoneIn = 1'b0;
      end else begin
        tick();
      end
    end
    chk("load_state", 256'(stateOut), 256'(3));
    chk("load_drops", 256'(dropCountOut), 256'(6));
    firLoadIn = 1'b0;
    tick();
    chk("load_exit", 256'(stateOut), 256'(0));

    force dut.u_drop.cnt_q = 16'hFFFE;
    #1;
    release dut.u_drop.cnt_q;
    chk("drop_forced", 256'(dropCountOut), 256'(16'hFFFE));
    firLoadIn = 1'b1;
    tick();
    send(16'h6A00, 0);
    chk("drop_ffff", 256'(dropCountOut), 256'(16'hFFFF));
    send(16'h6B00, 0);
    send(16'h6C00, 0);
    chk("drop_sat", 256'(dropCountOut), 256'(16'hFFFF));
    firLoadIn = 1'b0;
    tick();

    send(16'h7000, 1);
    wait_start(lat);
    tick();
    tick();
    nResetIn = 1'b0;
    #1;
    chk("mid_rst_state", 256'(stateOut), 256'(0));
    chk("mid_rst_busy", 256'(busyOut), 256'(0));
    chk("mid_rst_start", 256'(firStartOut), 256'(0));
    chk("mid_rst_fdata", 256'(firDataOut), 256'(0));
    chk("mid_rst_tx", 256'(txDataOut), 256'(0));
    chk("mid_rst_drop", 256'(dropCountOut), 256'(0));
    chk("mid_rst_tmo", 256'(timeoutCountOut), 256'(0));
    res_m = '0;
    tick();
    tick();
    nResetIn = 1'b1;
    for (int c = 0; c < 10; c++)
      tick();
    chk("post_rst_idle", 256'(stateOut), 256'(0));
    send(16'h7100, 1);
    wait_start(lat);
    chk("post_rst_latency", 256'(lat), 256'(2));
    done(32'h11111111);
    tick();
    tick();
    chk("jobs_left", 256'(exp_job.size()), 256'(0));
    chk("tx_left", 256'(exp_tx.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
